// File: rtl/alu_issuer_if.sv
// Command/response handshake bundle between an ALU issuer and its producer/consumer.
// The slave modport is the issuer's view of the bundle; master is the opposite side.
interface alu_issuer_if #(
  parameter int WIDTH = 32
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [3:0]       cmd_op;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_zero;
  logic [3:0]       rsp_op;

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_op
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_zero, rsp_op
  );
endinterface

// File: rtl/alu_issuer.sv
// Queues ALU commands in a small FIFO and issues them one at a time to an external
// ALU of fixed latency, capturing each result into a held response register.
module alu_issuer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  alu_issuer_if.slave            bus,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic [3:0]             alu_op,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic                   alu_zero,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
  localparam int EW = 2 * WIDTH + 4;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [LW-1:0] LAT_LOAD = LW'(ALU_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state_r, state_nx_s;
  logic [LW-1:0]    cnt_r, cnt_nx_s;
  logic [EW-1:0]    mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r, count_nx_s;
  logic             cmd_ready_r, busy_r;
  logic [WIDTH-1:0] alu_a_r, alu_b_r, rsp_result_r;
  logic [3:0]       alu_op_r, rsp_op_r;
  logic             rsp_zero_r, rsp_valid_r;
  logic             push_s, pop_s, sample_s, rsp_clr_s;
  logic [EW-1:0]    head_s;

  assign head_s = mem_r[rd_ptr_r];

  // Sequencer next-state: issue from FIFO, count down ALU latency, hold response.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    pop_s      = 1'b0;
    sample_s   = 1'b0;
    rsp_clr_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (count_r != {CW{1'b0}}) begin
          pop_s      = 1'b1;
          cnt_nx_s   = LAT_LOAD;
          state_nx_s = S_WAIT;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_r != {LW{1'b0}}) begin
          cnt_nx_s = cnt_r - LW'(1);
        end else begin
          sample_s   = 1'b1;
          state_nx_s = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.rsp_ready) begin
          rsp_clr_s  = 1'b1;
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_HOLD;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
        cnt_nx_s   = {LW{1'b0}};
      end
    endcase
  end

  // Occupancy update; cmd_ready comes only from registered state.
  always_comb begin
    push_s = bus.cmd_valid & cmd_ready_r;
    case ({push_s, pop_s})
      2'b10:   count_nx_s = count_r + CW'(1);
      2'b01:   count_nx_s = count_r - CW'(1);
      default: count_nx_s = count_r;
    endcase
  end

  // Command storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op};
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Control, pointer, operand and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      cnt_r        <= {LW{1'b0}};
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      cmd_ready_r  <= 1'b0;
      busy_r       <= 1'b0;
      alu_a_r      <= {WIDTH{1'b0}};
      alu_b_r      <= {WIDTH{1'b0}};
      alu_op_r     <= 4'd0;
      rsp_result_r <= {WIDTH{1'b0}};
      rsp_zero_r   <= 1'b0;
      rsp_op_r     <= 4'd0;
      rsp_valid_r  <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      count_r     <= count_nx_s;
      cmd_ready_r <= (count_nx_s < FULL);
      busy_r      <= (state_nx_s != S_IDLE) || (count_nx_s != {CW{1'b0}});
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
        alu_a_r  <= head_s[EW-1 -: WIDTH];
        alu_b_r  <= head_s[4 +: WIDTH];
        alu_op_r <= head_s[3:0];
      end
      if (sample_s) begin
        rsp_result_r <= alu_result;
        rsp_zero_r   <= alu_zero;
        rsp_op_r     <= alu_op_r;
        rsp_valid_r  <= 1'b1;
      end else if (rsp_clr_s) begin
        rsp_valid_r <= 1'b0;
      end else begin
        rsp_valid_r <= rsp_valid_r;
      end
    end
  end

  assign bus.cmd_ready  = cmd_ready_r;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_result = rsp_result_r;
  assign bus.rsp_zero   = rsp_zero_r;
  assign bus.rsp_op     = rsp_op_r;
  assign alu_a          = alu_a_r;
  assign alu_b          = alu_b_r;
  assign alu_op         = alu_op_r;
  assign busy           = busy_r;
  assign count          = count_r;

endmodule

// File: tb/tb_alu_issuer.sv
// Self-checking bench for alu_issuer: a one-stage ALU model, a response queue
// scoreboard fed at command acceptance, and directed plus random scenarios.
module tb_alu_issuer;
  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 1;
  localparam int CW      = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             z;
    logic [3:0]       op;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_issuer_if #(.WIDTH(WIDTH)) bus ();
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [3:0]       alu_op;
  logic             alu_zero, busy;
  logic [CW-1:0]    count;

  alu_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .count(count)
  );

  int errors = 0;
  int checks = 0;
  int n_push = 0;
  int n_rsp  = 0;
  exp_t expq[$];
  exp_t e_m;
  logic [3:0] op_log[$];
  logic hold_prev = 1'b0;
  logic [WIDTH-1:0] prev_res;
  logic prev_z;
  logic [3:0] prev_op;
  logic settled = 1'b0;
  logic [3:0] burst_ops [4] = '{4'h0, 4'h5, 4'h7, 4'hA};
  logic [WIDTH-1:0] blk_res;

  function automatic logic [WIDTH-1:0] alu_fn(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [3:0] op);
    case (op)
      4'h0:    return a + b;
      4'h1:    return a - b;
      4'h2:    return a & b;
      4'h3:    return a | b;
      4'h4:    return a ^ b;
      4'h5:    return a << b[4:0];
      4'h6:    return a >> b[4:0];
      4'h7:    return (a < b) ? 32'd1 : 32'd0;
      default: return ~(a | b);
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // External ALU with one register stage.
  initial begin
    alu_result = 32'd0;
    alu_zero   = 1'b0;
  end
  always @(posedge clk) begin
    alu_result <= alu_fn(alu_a, alu_b, alu_op);
    alu_zero   <= (alu_fn(alu_a, alu_b, alu_op) == 32'd0);
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) settled <= 1'b0;
    else        settled <= 1'b1;
  end

  // Scoreboard: record accepted commands, check every consumed response in order.
  always @(negedge clk) begin
    if (!reset) begin
      expq.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check_eq("hold_valid", bus.rsp_valid, 1'b1);
        check_eq("hold_result", bus.rsp_result, prev_res);
        check_eq("hold_zero", bus.rsp_zero, prev_z);
        check_eq("hold_op", bus.rsp_op, prev_op);
      end
      hold_prev = bus.rsp_valid && !bus.rsp_ready;
      prev_res  = bus.rsp_result;
      prev_z    = bus.rsp_zero;
      prev_op   = bus.rsp_op;
      check_eq("count_bound", (count <= DEPTH), 1'b1);
      if (settled) check_eq("cmd_ready_vs_count", bus.cmd_ready, (count < DEPTH));
      if (bus.rsp_valid && bus.rsp_ready) begin
        check_eq("rsp_expected", (expq.size() > 0), 1'b1);
        if (expq.size() > 0) begin
          e_m = expq.pop_front();
          check_eq("rsp_result", bus.rsp_result, e_m.res);
          check_eq("rsp_zero", bus.rsp_zero, e_m.z);
          check_eq("rsp_op", bus.rsp_op, e_m.op);
        end
        op_log.push_back(bus.rsp_op);
        n_rsp++;
      end
      if (bus.cmd_valid && bus.cmd_ready) begin
        e_m.res = alu_fn(bus.cmd_a, bus.cmd_b, bus.cmd_op);
        e_m.z   = (e_m.res == 32'd0);
        e_m.op  = bus.cmd_op;
        expq.push_back(e_m);
        n_push++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [3:0] op);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.rsp_valid && n < 50) begin
      tick();
      n++;
    end
    check_eq(tag, bus.rsp_valid, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || expq.size() != 0 || bus.rsp_valid) && n < 200) begin
      tick();
      n++;
    end
    check_eq(tag, busy, 1'b0);
  endtask

  initial begin
    int cyc;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = 32'd0;
    bus.cmd_b     = 32'd0;
    bus.cmd_op    = 4'd0;
    bus.rsp_ready = 1'b1;
    reset = 1'b0;
    repeat (3) tick();

    // Reset values
    check_eq("rst_cmd_ready", bus.cmd_ready, 1'b0);
    check_eq("rst_alu_a", alu_a, 32'd0);
    check_eq("rst_alu_b", alu_b, 32'd0);
    check_eq("rst_alu_op", alu_op, 4'd0);
    check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check_eq("rst_rsp_result", bus.rsp_result, 32'd0);
    check_eq("rst_rsp_zero", bus.rsp_zero, 1'b0);
    check_eq("rst_rsp_op", bus.rsp_op, 4'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_count", count, 0);
    reset = 1'b1;
    tick();
    check_eq("rel_cmd_ready", bus.cmd_ready, 1'b1);

    // Single op latency
    push(32'h1B, 32'h2E, 4'h0);
    check_eq("e0_count", count, 1);
    check_eq("e0_busy", busy, 1'b1);
    check_eq("e0_alu_a", alu_a, 32'd0);
    tick();
    check_eq("e1_alu_a", alu_a, 32'h1B);
    check_eq("e1_alu_b", alu_b, 32'h2E);
    check_eq("e1_alu_op", alu_op, 4'h0);
    check_eq("e1_rsp_valid", bus.rsp_valid, 1'b0);
    tick();
    check_eq("e2_rsp_valid", bus.rsp_valid, 1'b0);
    tick();
    check_eq("e3_rsp_valid", bus.rsp_valid, 1'b1);
    check_eq("e3_rsp_result", bus.rsp_result, 32'h49);
    check_eq("e3_rsp_op", bus.rsp_op, 4'h0);
    tick();
    check_eq("e4_rsp_valid", bus.rsp_valid, 1'b0);
    wait_idle("single_idle");

    // Burst behind a held response, full FIFO, backpressure
    op_log.delete();
    bus.rsp_ready = 1'b0;
    blk_res = alu_fn(32'd5, 32'd3, 4'hF);
    push(32'd5, 32'd3, 4'hF);
    wait_valid("blk_valid_timeout");
    for (int i = 0; i < 4; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_a     = 32'h100 + i;
      bus.cmd_b     = i;
      bus.cmd_op    = burst_ops[i];
      tick();
    end
    check_eq("full_count", count, 4);
    check_eq("full_cmd_ready", bus.cmd_ready, 1'b0);
    bus.cmd_a  = 32'hDEAD;
    bus.cmd_op = 4'h3;
    tick();
    tick();
    bus.cmd_valid = 1'b0;
    check_eq("full_hold_count", count, 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_valid", bus.rsp_valid, 1'b1);
      check_eq("bp_result", bus.rsp_result, blk_res);
      check_eq("bp_op", bus.rsp_op, 4'hF);
      check_eq("bp_no_issue", alu_op, 4'hF);
    end
    bus.rsp_ready = 1'b1;
    tick();
    check_eq("exit_valid", bus.rsp_valid, 1'b0);
    check_eq("exit_alu_op", alu_op, 4'hF);
    tick();
    check_eq("next_alu_op", alu_op, 4'h0);
    check_eq("next_alu_a", alu_a, 32'h100);
    check_eq("next_count", count, 3);
    wait_idle("burst_idle");
    check_eq("burst_n", op_log.size(), 5);
    if (op_log.size() == 5) begin
      check_eq("burst_op0", op_log[0], 4'hF);
      for (int i = 0; i < 4; i++) check_eq("burst_order", op_log[i+1], burst_ops[i]);
    end

    // Zero flag
    push(32'd0, 32'd0, 4'h0);
    wait_valid("zero_valid_timeout");
    check_eq("zero_flag", bus.rsp_zero, 1'b1);
    check_eq("zero_result", bus.rsp_result, 32'd0);
    wait_idle("zero_idle");

    // Reset in WAIT with three commands still queued
    bus.rsp_ready = 1'b0;
    push(32'd9, 32'd1, 4'h1);
    wait_valid("rw_valid_timeout");
    for (int i = 0; i < 4; i++) push(32'h200 + i, 32'd2, 4'h4);
    bus.rsp_ready = 1'b1;
    tick();
    tick();
    check_eq("rw_pre_count", count, 3);
    check_eq("rw_pre_alu_a", alu_a, 32'h200);
    reset = 1'b0;
    #1;
    check_eq("rw_count", count, 0);
    check_eq("rw_rsp_valid", bus.rsp_valid, 1'b0);
    check_eq("rw_alu_a", alu_a, 32'd0);
    check_eq("rw_alu_b", alu_b, 32'd0);
    check_eq("rw_alu_op", alu_op, 4'd0);
    check_eq("rw_cmd_ready", bus.cmd_ready, 1'b0);
    tick();
    reset = 1'b1;
    op_log.delete();
    repeat (15) tick();
    check_eq("rw_no_rsp", op_log.size(), 0);
    check_eq("rw_cmd_ready_after", bus.cmd_ready, 1'b1);
    check_eq("rw_busy_after", busy, 1'b0);

    // Random traffic with consumer stalls
    n_push = 0;
    n_rsp  = 0;
    cyc    = 0;
    while (n_push < 40 && cyc < 2000) begin
      bus.cmd_valid = ($urandom_range(0, 2) != 0);
      bus.cmd_a     = $urandom;
      bus.cmd_b     = ($urandom_range(0, 3) == 0) ? bus.cmd_a : $urandom;
      bus.cmd_op    = 4'($urandom_range(0, 15));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    bus.cmd_valid = 1'b0;
    check_eq("rand_push_timeout", n_push, 40);
    cyc = 0;
    while ((expq.size() != 0 || busy) && cyc < 2000) begin
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
      tick();
      cyc++;
    end
    bus.rsp_ready = 1'b1;
    check_eq("rand_drain", (expq.size() == 0 && !busy), 1'b1);
    check_eq("rand_rsp_count", n_rsp, 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 Parameter WIDTH, 32, operand/result width.
REQ-002 Parameter DEPTH, 4, command FIFO entries (power of 2, >=2).
REQ-003 Parameter ALU_LAT, 1, ALU register stages between operand change and result (0 = combinational ALU).
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  FIFO can accept a command.
REQ-008 cmd_a, cmd_b  in  WIDTH  operands.
REQ-009 cmd_op  in  4  ALU opcode, passed through uninterpreted.
REQ-010 alu_a, alu_b  out  WIDTH  registered operands to the ALU A/B ports.
REQ-011 alu_op  out  4  registered opcode to the ALU Opin port.
REQ-012 alu_result  in  WIDTH  ALU result.
REQ-013 alu_zero  in  1  ALU zero flag.
REQ-014 rsp_valid  out  1  response available.
REQ-015 rsp_ready  in  1  consumer accepts response.
REQ-016 rsp_result  out  WIDTH; rsp_zero  out  1; rsp_op  out  4  captured response and its opcode.
REQ-017 busy  out  1  high when FSM is not IDLE or FIFO is non-empty.
REQ-018 count  out  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-019 Command transfers on a rising edge with cmd_valid=1 and cmd_ready=1; {cmd_a, cmd_b, cmd_op} written at the write pointer.
REQ-020 cmd_ready SHALL equal (count < DEPTH) from registered state only; a same-cycle pop does not raise it.
REQ-021 Full FIFO: cmd_valid ignored, no overwrite, count holds at DEPTH.
REQ-022 Pointers wrap modulo DEPTH; simultaneous push and pop leave count unchanged.
REQ-023 FSM states: IDLE, WAIT, HOLD.
REQ-024 IDLE: FIFO non-empty -> pop head into alu_a/alu_b/alu_op, load wait counter with ALU_LAT, go WAIT; empty -> stay.
REQ-025 WAIT: counter non-zero -> decrement; counter zero -> sample alu_result/alu_zero into rsp_result/rsp_zero, alu_op into rsp_op, set rsp_valid, go HOLD.
REQ-026 Sampling therefore occurs at the (ALU_LAT+1)th rising edge after the edge that updated alu_a/alu_b/alu_op.
REQ-027 HOLD: rsp_valid=1 and rsp_* stable until an edge with rsp_ready=1; then clear rsp_valid, go IDLE.
REQ-028 Latency: command accepted at edge 0 into empty idle block -> issued at edge 1 -> rsp_valid high after edge 2+ALU_LAT.
REQ-029 Throughput: one command per ALU_LAT+3 cycles with rsp_ready held high.
REQ-030 alu_a/alu_b/alu_op hold last issued values until next issue.
REQ-031 Responses leave in command order; none dropped or duplicated.
REQ-032 rsp_ready while rsp_valid=0 has no effect.

Reset
REQ-033 reset low asynchronously clears FIFO pointers and count, FSM to IDLE, wait counter 0.
REQ-034 Reset values: cmd_ready 0 while reset low, 1 after release; alu_a, alu_b, alu_op, rsp_result, rsp_zero, rsp_op, rsp_valid, busy, count all 0.
REQ-035 Reset mid-operation discards queued and in-flight commands; no response issued for them after release.

Verification
REQ-036 Single op, ALU_LAT=1, rsp_ready=1: A=0x1B, B=0x2E, op=4'b0000 at edge 0 -> alu_* updated edge 1, rsp_valid after edge 3, rsp_op=0, rsp_result equals ALU output.
REQ-037 Burst: ops 0000,0101,0111,1010 back-to-back -> cmd_ready drops after 4th accepted, count=4; four responses in order with rsp_op 0,5,7,A.
REQ-038 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_result/rsp_zero/rsp_op unchanged, no new issue; rsp_ready=1 -> next command issues one cycle after HOLD exit.
REQ-039 Zero flag: A=B=0 with a passing op, ALU drives zero=1 -> rsp_zero=1, rsp_result=0.
REQ-040 Reset mid-WAIT with 3 queued: reset low 1 cycle -> count=0, rsp_valid=0, alu_*=0, no response after release, cmd_ready=1.
REQ-041 Wrap: 10 commands with random rsp_ready stalls -> 10 responses in order, count never exceeds DEPTH.
